// File: rtl/node_endpoint_if.sv
// node_endpoint_if: host send/receive and router core handshake signals of one processor node.
interface node_endpoint_if;
  logic        Host_Send_Valid;
  logic        Host_Send_Ready;
  logic [3:0]  Host_Send_Dest;
  logic        Host_Send_Ack_Req;
  logic [23:0] Host_Send_Payload;
  logic        Send_Err;
  logic [28:0] Packet_From_Node;
  logic        Packet_From_Node_Valid;
  logic        Core_Load_Ack;
  logic [23:0] Packet_To_Node;
  logic        Packet_To_Node_Valid;
  logic [23:0] Host_Rcv_Payload;
  logic        Host_Rcv_Valid;
  logic        Host_Rcv_Ready;
  logic        Rx_Overflow;
  logic        Ack_Timeout;
  logic [7:0]  Tx_Count;
  logic [7:0]  Rx_Count;
  modport slave (
    input  Host_Send_Valid, Host_Send_Dest, Host_Send_Ack_Req, Host_Send_Payload,
    input  Core_Load_Ack, Packet_To_Node, Packet_To_Node_Valid, Host_Rcv_Ready,
    output Host_Send_Ready, Send_Err, Packet_From_Node, Packet_From_Node_Valid,
    output Host_Rcv_Payload, Host_Rcv_Valid, Rx_Overflow, Ack_Timeout, Tx_Count, Rx_Count
  );
  modport master (
    output Host_Send_Valid, Host_Send_Dest, Host_Send_Ack_Req, Host_Send_Payload,
    output Core_Load_Ack, Packet_To_Node, Packet_To_Node_Valid, Host_Rcv_Ready,
    input  Host_Send_Ready, Send_Err, Packet_From_Node, Packet_From_Node_Valid,
    input  Host_Rcv_Payload, Host_Rcv_Valid, Rx_Overflow, Ack_Timeout, Tx_Count, Rx_Count
  );
endinterface

// File: rtl/node_endpoint.sv
// node_endpoint: node side of the router core handshake with TX/RX FIFOs; NODE_STATS_EN adds saturating Tx/Rx counters.
module node_endpoint #(
  parameter logic [3:0] OUR_ADDRESS = 4'd0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input logic Clk_R,
  input logic Rst_n,
  node_endpoint_if.slave nif
);
  localparam int TW = $clog2(TX_DEPTH);
  localparam int RW = $clog2(RX_DEPTH);
  localparam int TP = TW + 1;
  localparam int RP = RW + 1;
  typedef enum logic [1:0] {IDLE, PRESENT, GAP} tx_state_e;
  tx_state_e state_q, state_d;
  logic [28:0] tx_mem_q [TX_DEPTH];
  logic [28:0] tx_mem_d [TX_DEPTH];
  logic [23:0] rx_mem_q [RX_DEPTH];
  logic [23:0] rx_mem_d [RX_DEPTH];
  logic [TW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [7:0] timer_q, timer_d;
  logic send_err_q, send_err_d, rx_ovf_q, rx_ovf_d, ack_to_q, ack_to_d;
  logic tx_empty, tx_full, tx_accept, tx_push, tx_pop, in_present, acked, expired;
  logic rx_empty, rx_full, rx_pop, rx_push;
  assign tx_empty = tx_wr_q == tx_rd_q;
  assign tx_full = (tx_wr_q[TW] != tx_rd_q[TW]) && (tx_wr_q[TW-1:0] == tx_rd_q[TW-1:0]);
  assign rx_empty = rx_wr_q == rx_rd_q;
  assign rx_full = (rx_wr_q[RW] != rx_rd_q[RW]) && (rx_wr_q[RW-1:0] == rx_rd_q[RW-1:0]);
  assign tx_accept = nif.Host_Send_Valid && !tx_full;
  assign tx_push = tx_accept && nif.Host_Send_Dest != OUR_ADDRESS;
  assign in_present = state_q == PRESENT;
  assign acked = in_present && nif.Core_Load_Ack;
  // timer counts completed PRESENT cycles, so the last allowed cycle is ACK_TIMEOUT-1
  assign expired = in_present && !nif.Core_Load_Ack && timer_q == 8'(ACK_TIMEOUT - 1);
  assign tx_pop = acked || expired;
  assign rx_pop = !rx_empty && nif.Host_Rcv_Ready;
  assign rx_push = nif.Packet_To_Node_Valid && (!rx_full || rx_pop);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = tx_empty ? IDLE : PRESENT;
      PRESENT: state_d = tx_pop ? GAP : PRESENT;
      default: state_d = IDLE;
    endcase
    timer_d = (in_present && !tx_pop) ? timer_q + 8'd1 : 8'd0;
    tx_wr_d = tx_wr_q + TP'(tx_push);
    tx_rd_d = tx_rd_q + TP'(tx_pop);
    rx_wr_d = rx_wr_q + RP'(rx_push);
    rx_rd_d = rx_rd_q + RP'(rx_pop);
    tx_mem_d = tx_mem_q;
    if (tx_push) tx_mem_d[tx_wr_q[TW-1:0]] = {nif.Host_Send_Dest, nif.Host_Send_Ack_Req, nif.Host_Send_Payload};
    rx_mem_d = rx_mem_q;
    if (rx_push) rx_mem_d[rx_wr_q[RW-1:0]] = nif.Packet_To_Node;
    send_err_d = tx_accept && nif.Host_Send_Dest == OUR_ADDRESS;
    rx_ovf_d = rx_ovf_q || (nif.Packet_To_Node_Valid && !rx_push);
    ack_to_d = ack_to_q || expired;
  end
  always_ff @(posedge Clk_R) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      tx_mem_q <= '{default: '0};
      rx_mem_q <= '{default: '0};
      send_err_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      ack_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
      send_err_q <= send_err_d;
      rx_ovf_q <= rx_ovf_d;
      ack_to_q <= ack_to_d;
    end
  end
  assign nif.Host_Send_Ready = !tx_full;
  assign nif.Send_Err = send_err_q;
  assign nif.Packet_From_Node_Valid = in_present;
  assign nif.Packet_From_Node = in_present ? tx_mem_q[tx_rd_q[TW-1:0]] : '0;
  assign nif.Host_Rcv_Valid = !rx_empty;
  assign nif.Host_Rcv_Payload = rx_mem_q[rx_rd_q[RW-1:0]];
  assign nif.Rx_Overflow = rx_ovf_q;
  assign nif.Ack_Timeout = ack_to_q;
`ifdef NODE_STATS_EN
  logic [7:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  always_comb begin
    tx_cnt_d = tx_cnt_q + 8'(acked && tx_cnt_q != 8'hFF);
    rx_cnt_d = rx_cnt_q + 8'(rx_push && rx_cnt_q != 8'hFF);
  end
  always_ff @(posedge Clk_R) begin
    if (!Rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end
  assign nif.Tx_Count = tx_cnt_q;
  assign nif.Rx_Count = rx_cnt_q;
`else
  assign nif.Tx_Count = '0;
  assign nif.Rx_Count = '0;
`endif
endmodule

// File: tb/tb_node_endpoint.sv
// tb_node_endpoint: queue-based reference model plus directed and random stimulus for node_endpoint.
module tb_node_endpoint;
  logic clk = 1'b0;
  logic rst_n;
  bit chk_en = 1'b0;
  int total = 0;
  int bad = 0;
  node_endpoint_if nif ();
  node_endpoint dut (.Clk_R(clk), .Rst_n(rst_n), .nif(nif));
  always #5 clk = ~clk;
  logic [28:0] tq[$];
  logic [23:0] rq[$];
  bit m_pres, m_err, m_ovf, m_ato, m_push, m_pop, m_rpop, m_rpush;
  int m_vc, m_hold, m_txc, m_rxc;
  function automatic int exp_cnt(int c);
`ifdef NODE_STATS_EN
    return c > 255 ? 255 : c;
`else
    return 0;
`endif
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      tq.delete();
      rq.delete();
      m_pres = 0; m_err = 0; m_ovf = 0; m_ato = 0;
      m_vc = 0; m_hold = 0; m_txc = 0; m_rxc = 0;
    end else begin
      m_push = nif.Host_Send_Valid && tq.size() < 4 && nif.Host_Send_Dest != 4'd0;
      m_err = nif.Host_Send_Valid && tq.size() < 4 && nif.Host_Send_Dest == 4'd0;
      m_pop = 0;
      if (m_pres) begin
        if (nif.Core_Load_Ack) begin m_pop = 1; m_txc++; end
        else if (m_vc + 1 == 255) begin m_pop = 1; m_ato = 1; end
        else m_vc++;
        if (m_pop) begin m_pres = 0; m_hold = 1; end
      end else if (m_hold > 0) m_hold--;
      else if (tq.size() > 0) begin m_pres = 1; m_vc = 0; end
      m_rpop = rq.size() > 0 && nif.Host_Rcv_Ready;
      m_rpush = nif.Packet_To_Node_Valid && (rq.size() < 4 || m_rpop);
      if (nif.Packet_To_Node_Valid && !m_rpush) m_ovf = 1;
      if (m_pop) void'(tq.pop_front());
      if (m_push) tq.push_back({nif.Host_Send_Dest, nif.Host_Send_Ack_Req, nif.Host_Send_Payload});
      if (m_rpop) void'(rq.pop_front());
      if (m_rpush) begin rq.push_back(nif.Packet_To_Node); m_rxc++; end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("ready", nif.Host_Send_Ready, tq.size() < 4);
    chk("pfn_valid", nif.Packet_From_Node_Valid, m_pres);
    if (m_pres) chk("pfn_data", nif.Packet_From_Node, tq[0]);
    chk("send_err", nif.Send_Err, m_err);
    chk("rcv_valid", nif.Host_Rcv_Valid, rq.size() > 0);
    if (rq.size() > 0) chk("rcv_payload", nif.Host_Rcv_Payload, rq[0]);
    chk("rx_overflow", nif.Rx_Overflow, m_ovf);
    chk("ack_timeout", nif.Ack_Timeout, m_ato);
    chk("tx_count", nif.Tx_Count, exp_cnt(m_txc));
    chk("rx_count", nif.Rx_Count, exp_cnt(m_rxc));
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic do_reset;
    rst_n = 0;
    repeat (2) tick;
    rst_n = 1;
  endtask
  task automatic send(logic [3:0] d, logic a, logic [23:0] p);
    nif.Host_Send_Valid = 1; nif.Host_Send_Dest = d; nif.Host_Send_Ack_Req = a; nif.Host_Send_Payload = p;
    tick;
    nif.Host_Send_Valid = 0;
  endtask
  task automatic wait_valid;
    for (int i = 0; i < 10 && !nif.Packet_From_Node_Valid; i++) tick;
  endtask
  initial begin
    rst_n = 0;
    nif.Host_Send_Valid = 0; nif.Host_Send_Dest = 0; nif.Host_Send_Ack_Req = 0; nif.Host_Send_Payload = 0;
    nif.Core_Load_Ack = 0; nif.Packet_To_Node = 0; nif.Packet_To_Node_Valid = 0; nif.Host_Rcv_Ready = 0;
    tick;
    chk_en = 1;
    tick;
    chk("rst_ready", nif.Host_Send_Ready, 1);
    chk("rst_valid", nif.Packet_From_Node_Valid, 0);
    chk("rst_pfn", nif.Packet_From_Node, 0);
    chk("rst_rcv_valid", nif.Host_Rcv_Valid, 0);
    chk("rst_flags", {nif.Rx_Overflow, nif.Ack_Timeout, nif.Send_Err}, 0);
    rst_n = 1;
    send(4'h3, 1'b1, 24'hABCDEF);
    wait_valid;
    chk("d1_valid1", nif.Packet_From_Node_Valid, 1);
    chk("d1_pkt1", nif.Packet_From_Node, 29'h07ABCDEF);
    tick;
    chk("d1_pkt2", nif.Packet_From_Node, 29'h07ABCDEF);
    tick;
    chk("d1_pkt3", nif.Packet_From_Node, 29'h07ABCDEF);
    nif.Core_Load_Ack = 1;
    tick;
    nif.Core_Load_Ack = 0;
    chk("d1_valid_after_ack", nif.Packet_From_Node_Valid, 0);
    chk("d1_tx_count", nif.Tx_Count, exp_cnt(1));
    repeat (2) tick;
    for (int i = 0; i < 4; i++) send(4'h5, 1'b0, 24'h000100 + 24'(i));
    chk("d2_full_ready", nif.Host_Send_Ready, 0);
    for (int i = 0; i < 300 && !nif.Ack_Timeout; i++) tick;
    chk("d2_timeout", nif.Ack_Timeout, 1);
    chk("d2_ready_back", nif.Host_Send_Ready, 1);
    chk("d2_gap", nif.Packet_From_Node_Valid, 0);
    tick;
    chk("d2_idle", nif.Packet_From_Node_Valid, 0);
    tick;
    chk("d2_second_valid", nif.Packet_From_Node_Valid, 1);
    chk("d2_second_pkt", nif.Packet_From_Node, 29'h0A000101);
    nif.Core_Load_Ack = 1;
    repeat (20) tick;
    nif.Core_Load_Ack = 0;
    chk("d2_tx_count", nif.Tx_Count, exp_cnt(4));
    send(4'h0, 1'b1, 24'h111111);
    chk("d3_err_pulse", nif.Send_Err, 1);
    chk("d3_no_valid", nif.Packet_From_Node_Valid, 0);
    tick;
    chk("d3_err_clear", nif.Send_Err, 0);
    chk("d3_no_valid2", nif.Packet_From_Node_Valid, 0);
    for (int v = 1; v <= 5; v++) begin
      nif.Packet_To_Node = 24'(v); nif.Packet_To_Node_Valid = 1;
      tick;
    end
    nif.Packet_To_Node_Valid = 0;
    chk("d4_overflow", nif.Rx_Overflow, 1);
    nif.Host_Rcv_Ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk("d4_order", nif.Host_Rcv_Payload, 32'(k));
      tick;
    end
    nif.Host_Rcv_Ready = 0;
    chk("d4_empty", nif.Host_Rcv_Valid, 0);
    chk("d4_rx_count", nif.Rx_Count, exp_cnt(4));
    do_reset;
    for (int v = 1; v <= 4; v++) begin
      nif.Packet_To_Node = 24'(v); nif.Packet_To_Node_Valid = 1;
      tick;
    end
    nif.Packet_To_Node = 24'd5; nif.Host_Rcv_Ready = 1;
    tick;
    nif.Packet_To_Node_Valid = 0; nif.Host_Rcv_Ready = 0;
    chk("d5_no_overflow", nif.Rx_Overflow, 0);
    chk("d5_head", nif.Host_Rcv_Payload, 24'd2);
    send(4'h2, 1'b0, 24'h000123);
    wait_valid;
    chk("d6_present", nif.Packet_From_Node_Valid, 1);
    rst_n = 0;
    tick;
    chk("d6_rst_valid", nif.Packet_From_Node_Valid, 0);
    chk("d6_rst_rcv", nif.Host_Rcv_Valid, 0);
    rst_n = 1;
    for (int c = 0; c < 4000; c++) begin
      int blk;
      blk = c / 500;
      nif.Host_Send_Valid = $urandom_range(0, 1);
      nif.Host_Send_Dest = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      nif.Host_Send_Ack_Req = 1'($urandom);
      nif.Host_Send_Payload = 24'($urandom);
      nif.Core_Load_Ack = (blk % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
      nif.Packet_To_Node = 24'($urandom);
      nif.Packet_To_Node_Valid = $urandom_range(0, 2) == 0;
      nif.Host_Rcv_Ready = (blk % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      tick;
    end
    nif.Host_Send_Valid = 0; nif.Packet_To_Node_Valid = 0; nif.Core_Load_Ack = 0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
